// File: rtl/agtb_max_track.sv
// agtb_n: N-bit unsigned magnitude comparator with cascade inputs.
// A difference in a higher bit overrides any difference in lower bits. When
// A==B the cascade inputs pass through, so the result can be chained.
module agtb_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         AGTBI,
  input  logic         AEQBI,
  output logic         AGTBO,
  output logic         AEQBO
);

  logic gt_c;
  logic eq_c;

  // Ripple from LSB to MSB; the most significant differing bit decides.
  always_comb begin
    gt_c = AGTBI;
    eq_c = AEQBI;
    for (int unsigned i = 0; i < N; i++) begin
      if (A[i] != B[i]) begin
        gt_c = A[i];
        eq_c = 1'b0;
      end
    end
  end

  assign AGTBO = gt_c;
  assign AEQBO = eq_c;

endmodule

// agtb_max_track: per-window maximum, first-occurrence index and all-equal
// flag over windows of W unsigned N-bit samples, valid/ready on both sides.
module agtb_max_track #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_max,
  output logic [$clog2(W)-1:0] out_idx,
  output logic                 out_all_eq
);

  localparam int IW = $clog2(W);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t        state_q, state_d;

  logic [IW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  acc_max_q, acc_max_d;
  logic [IW-1:0] acc_idx_q, acc_idx_d;
  logic          acc_eq_q, acc_eq_d;

  logic [N-1:0]  res_max_q, res_max_d;
  logic [IW-1:0] res_idx_q, res_idx_d;
  logic          res_eq_q, res_eq_d;

  logic          cmp_gt;
  logic          cmp_eq;
  logic          last_c;
  logic          in_fire;
  logic          out_fire;
  logic          complete;

  agtb_n #(
    .N(N)
  ) u_cmp (
    .A     (in_data),
    .B     (acc_max_q),
    .AGTBI (1'b0),
    .AEQBI (1'b1),
    .AGTBO (cmp_gt),
    .AEQBO (cmp_eq)
  );

  assign last_c    = (cnt_q == IW'(W - 1));
  assign out_valid = (state_q == ST_FULL);
  // Only a completing sample can stall, and only if it would overwrite an
  // unconsumed result; a same-cycle consume frees the slot.
  assign in_ready  = ~(last_c & out_valid & ~out_ready);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign complete  = in_fire & last_c;

  assign out_max    = res_max_q;
  assign out_idx    = res_idx_q;
  assign out_all_eq = res_eq_q;

  // Accumulator next state: first sample seeds, later samples fold in.
  always_comb begin
    cnt_d     = cnt_q;
    acc_max_d = acc_max_q;
    acc_idx_d = acc_idx_q;
    acc_eq_d  = acc_eq_q;
    if (in_fire) begin
      if (cnt_q == '0) begin
        acc_max_d = in_data;
        acc_idx_d = '0;
        acc_eq_d  = 1'b1;
      end else begin
        if (cmp_gt) begin
          acc_max_d = in_data;
          acc_idx_d = cnt_q;
        end
        acc_eq_d = acc_eq_q & cmp_eq;
      end
      cnt_d = last_c ? '0 : cnt_q + IW'(1);
    end
  end

  // Result registers capture the accumulator including the final sample.
  always_comb begin
    res_max_d = res_max_q;
    res_idx_d = res_idx_q;
    res_eq_d  = res_eq_q;
    if (complete) begin
      res_max_d = acc_max_d;
      res_idx_d = acc_idx_d;
      res_eq_d  = acc_eq_d;
    end
  end

  // Result slot occupancy: completion fills it, a consume alone drains it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (complete) state_d = ST_FULL;
      ST_FULL:  if (out_fire && !complete) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      cnt_q     <= '0;
      acc_max_q <= '0;
      acc_idx_q <= '0;
      acc_eq_q  <= 1'b0;
      res_max_q <= '0;
      res_idx_q <= '0;
      res_eq_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_max_q <= acc_max_d;
      acc_idx_q <= acc_idx_d;
      acc_eq_q  <= acc_eq_d;
      res_max_q <= res_max_d;
      res_idx_q <= res_idx_d;
      res_eq_q  <= res_eq_d;
    end
  end

endmodule

// File: tb/tb_agtb_max_track.sv
// Bench for agtb_max_track with N=4, W=4; model results queued on accept.
module tb_agtb_max_track;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_max;
  logic [1:0] out_idx;
  logic       out_all_eq;

  int checks;
  int failures;

  typedef struct packed {
    logic [3:0] mx;
    logic [1:0] idx;
    logic       eq;
  } res_t;

  res_t exp_q[$];

  int         mcnt;
  logic [3:0] mmax;
  logic [1:0] midx;
  logic       meq;

  agtb_max_track #(
    .N(4),
    .W(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_max    (out_max),
    .out_idx    (out_idx),
    .out_all_eq (out_all_eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: updated on every accepted sample, queues window results.
  task automatic model_accept(input logic [3:0] d);
    if (mcnt == 0) begin
      mmax = d;
      midx = 2'd0;
      meq  = 1'b1;
    end else begin
      meq = meq & (d == mmax);
      if (d > mmax) begin
        mmax = d;
        midx = 2'(mcnt);
      end
    end
    if (mcnt == 3) begin
      exp_q.push_back('{mx: mmax, idx: midx, eq: meq});
      mcnt = 0;
    end else begin
      mcnt++;
    end
  endtask

  task automatic model_reset();
    mcnt = 0;
    mmax = '0;
    midx = '0;
    meq  = 1'b0;
    exp_q.delete();
  endtask

  function automatic res_t pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  function automatic res_t peek_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q[0];
  endfunction

  // Present one sample from the next falling edge until it is accepted.
  task automatic send(input logic [3:0] d, output int waited);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout: in_ready=%b required=1 data=%0d", in_ready, d);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(d);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    #3;
    checks++;
    if ({out_valid, out_max, out_idx, out_all_eq} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 00000000",
               {out_valid, out_max, out_idx, out_all_eq});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    logic [3:0] win[4] = '{4'd3, 4'd9, 4'd2, 4'd9};
    res_t e;
    int w;
    out_ready = 1'b1;
    foreach (win[i]) send(win[i], w);
    e = pop_exp();
    checks++;
    if (out_valid !== 1'b1 || {out_max, out_idx, out_all_eq} !== e) begin
      failures++;
      $display("FAIL basic_result: valid=%b max=%0d idx=%0d eq=%b required 1 %0d %0d %b",
               out_valid, out_max, out_idx, out_all_eq, e.mx, e.idx, e.eq);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_one_cycle: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_all_equal();
    logic [3:0] win[8] = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0};
    res_t e;
    int w;
    out_ready = 1'b1;
    foreach (win[i]) begin
      send(win[i], w);
      if (i % 4 == 3) begin
        e = pop_exp();
        checks++;
        if (out_valid !== 1'b1 || {out_max, out_idx, out_all_eq} !== e) begin
          failures++;
          $display("FAIL all_equal_%0d: valid=%b max=%0d idx=%0d eq=%b required 1 %0d %0d %b",
                   i / 4, out_valid, out_max, out_idx, out_all_eq, e.mx, e.idx, e.eq);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_boundary();
    logic [3:0] win[8] = '{4'd0, 4'd1, 4'd2, 4'd15, 4'd15, 4'd0, 4'd0, 4'd0};
    res_t e;
    int w;
    out_ready = 1'b1;
    foreach (win[i]) begin
      send(win[i], w);
      if (i % 4 == 3) begin
        e = pop_exp();
        checks++;
        if (out_valid !== 1'b1 || {out_max, out_idx, out_all_eq} !== e) begin
          failures++;
          $display("FAIL boundary_%0d: valid=%b max=%0d idx=%0d eq=%b required 1 %0d %0d %b",
                   i / 4, out_valid, out_max, out_idx, out_all_eq, e.mx, e.idx, e.eq);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] win[8] = '{4'd4, 4'd4, 4'd1, 4'd4, 4'd9, 4'd12, 4'd12, 4'd3};
    res_t e;
    int w;
    out_ready = 1'b1;
    foreach (win[i]) begin
      send(win[i], w);
      checks++;
      if (w != 0) begin
        failures++;
        $display("FAIL b2b_throughput: sample %0d waited %0d cycles required 0", i, w);
      end
      if (i % 4 == 3) begin
        e = pop_exp();
        checks++;
        if (out_valid !== 1'b1 || {out_max, out_idx, out_all_eq} !== e) begin
          failures++;
          $display("FAIL b2b_result_%0d: valid=%b max=%0d idx=%0d eq=%b required 1 %0d %0d %b",
                   i / 4, out_valid, out_max, out_idx, out_all_eq, e.mx, e.idx, e.eq);
        end
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] win[7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd7, 4'd6};
    res_t e;
    int w;
    out_ready = 1'b0;
    foreach (win[i]) send(win[i], w);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'd5;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_stall: in_ready=%b required 0", in_ready);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      e = peek_exp();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_max, out_idx, out_all_eq} !== e) begin
        failures++;
        $display("FAIL bp_hold_%0d: valid=%b ready=%b max=%0d idx=%0d eq=%b required 1 0 %0d %0d %b",
                 c, out_valid, in_ready, out_max, out_idx, out_all_eq, e.mx, e.idx, e.eq);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    e = pop_exp();
    checks++;
    if (in_ready !== 1'b1 || {out_max, out_idx, out_all_eq} !== e) begin
      failures++;
      $display("FAIL bp_release: ready=%b max=%0d idx=%0d eq=%b required 1 %0d %0d %b",
               in_ready, out_max, out_idx, out_all_eq, e.mx, e.idx, e.eq);
    end
    @(posedge clk);
    model_accept(4'd5);
    #1;
    in_valid = 1'b0;
    e = pop_exp();
    checks++;
    if (out_valid !== 1'b1 || {out_max, out_idx, out_all_eq} !== e) begin
      failures++;
      $display("FAIL bp_next: valid=%b max=%0d idx=%0d eq=%b required 1 %0d %0d %b",
               out_valid, out_max, out_idx, out_all_eq, e.mx, e.idx, e.eq);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] win[7] = '{4'd2, 4'd11, 4'd11, 4'd4, 4'd6, 4'd6, 4'd6};
    res_t e;
    int w;
    out_ready = 1'b0;
    foreach (win[i]) send(win[i], w);
    e = pop_exp();
    checks++;
    if (out_valid !== 1'b1 || {out_max, out_idx, out_all_eq} !== e) begin
      failures++;
      $display("FAIL sim_first: valid=%b max=%0d idx=%0d eq=%b required 1 %0d %0d %b",
               out_valid, out_max, out_idx, out_all_eq, e.mx, e.idx, e.eq);
    end
    out_ready = 1'b1;
    send(4'd6, w);
    e = pop_exp();
    checks++;
    if (out_valid !== 1'b1 || {out_max, out_idx, out_all_eq} !== e) begin
      failures++;
      $display("FAIL sim_replace: valid=%b max=%0d idx=%0d eq=%b required 1 %0d %0d %b",
               out_valid, out_max, out_idx, out_all_eq, e.mx, e.idx, e.eq);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL sim_once: out_valid=%b pending=%0d required 0 0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] win[6] = '{4'd2, 4'd6, 4'd6, 4'd1, 4'd7, 4'd9};
    logic [3:0] win2[4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    res_t e;
    int w;
    out_ready = 1'b0;
    foreach (win[i]) send(win[i], w);
    e = peek_exp();
    checks++;
    if (out_valid !== 1'b1 || {out_max, out_idx, out_all_eq} !== e) begin
      failures++;
      $display("FAIL ar_held: valid=%b max=%0d idx=%0d eq=%b required 1 %0d %0d %b",
               out_valid, out_max, out_idx, out_all_eq, e.mx, e.idx, e.eq);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({out_valid, out_max, out_idx, out_all_eq} !== 8'h00 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ar_clear: outputs=%b in_ready=%b required 00000000 1",
               {out_valid, out_max, out_idx, out_all_eq}, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    foreach (win2[i]) send(win2[i], w);
    e = pop_exp();
    checks++;
    if (out_valid !== 1'b1 || {out_max, out_idx, out_all_eq} !== e) begin
      failures++;
      $display("FAIL ar_after: valid=%b max=%0d idx=%0d eq=%b required 1 %0d %0d %b",
               out_valid, out_max, out_idx, out_all_eq, e.mx, e.idx, e.eq);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_all_equal();
    test_boundary();
    test_back_to_back();
    test_backpressure();
    test_simultaneous();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/agtb_max_track.md
# agtb_max_track

Streaming maximum tracker that sits directly downstream of the `agtb_n` magnitude comparator. It accepts unsigned N-bit samples through a valid/ready handshake and groups them into windows of W samples. For each window it reports the maximum value, the index of its first occurrence, and an all-equal flag. Each new sample is compared against the running maximum by an internal `agtb_n` instance, with cascade inputs tied to AGTBI=0 and AEQBI=1.

## Interface
- N, 4, sample width in bits; passed to `agtb_n`.
- W, 8, samples per window; must be >= 2.
- IW, $clog2(W), index width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_data holds a sample.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  N  unsigned sample.
- out_valid  output  1  result registers hold an unconsumed window result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_max  output  N  maximum of the completed window.
- out_idx  output  IW  position (0..W-1) of the first sample equal to out_max.
- out_all_eq  output  1  all W samples of the window were equal.

## Operation
- An input transfer occurs when in_valid & in_ready are both high at a rising edge. An output transfer occurs when out_valid & out_ready are both high.
- Internal accumulator state:
  - cnt: position of the next sample, 0..W-1.
  - acc_max[N], acc_idx[IW], acc_eq.
- Comparison: `agtb_n` with A=in_data, B=acc_max, AGTBI=0, AEQBI=1.
  - gt = AGTBO (strictly greater).
  - eq = AEQBO.
- On an input transfer with cnt==0: acc_max<=in_data, acc_idx<=0, acc_eq<=1. The comparator result is ignored.
- On an input transfer with cnt>0:
  - If gt, then acc_max<=in_data and acc_idx<=cnt.
  - Otherwise acc_max and acc_idx hold.
  - Ties never move acc_idx, so the first occurrence wins.
  - acc_eq<=acc_eq & eq.
- cnt increments on each input transfer and wraps from W-1 to 0.
- Window completion is an input transfer with cnt==W-1:
  - out_max, out_idx and out_all_eq load the updated values, i.e. including the final sample's effect.
  - out_valid<=1.
  - The accumulator starts the next window; cnt becomes 0.
- Result hold:
  - Without an output transfer, out_valid stays 1 and out_max/out_idx/out_all_eq are stable.
  - An output transfer without a same-cycle completion clears out_valid.
- Accumulation of the next window continues while a result is held.
- in_ready = ~((cnt==W-1) & out_valid & ~out_ready). Only a completing sample can stall, and only when it would overwrite an unconsumed result.
- Simultaneous output transfer and window completion: the new result loads, out_valid stays 1, and no result is lost or duplicated.
- Two states, implicit in out_valid:
  - EMPTY (out_valid=0) goes to FULL on completion.
  - FULL goes to EMPTY on an output transfer without completion.
  - FULL stays FULL on completion with an output transfer.

## Timing
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_max=0, out_idx=0, out_all_eq=0.
  - cnt=0, acc_max=0, acc_idx=0, acc_eq=0.
  - in_ready=1 while in reset and immediately after release.
- Reset mid-window discards the partial window. The first sample after reset is index 0.
- Latency: out_valid rises on the rising edge that accepts sample W-1, so the result is visible the cycle after the last accept.
- Throughput: one sample per cycle sustained while out_ready=1.
- in_ready depends combinationally on out_ready. There is no combinational path from in_data or in_valid to any output.
- The comparator path from in_data to the acc_* registers is single-cycle combinational.

## Test plan
Run with N=4, W=4.
1. Samples 3,9,2,9 with out_ready=1 -> out_valid for 1 cycle after the 4th accept; out_max=9, out_idx=1, out_all_eq=0.
2. Samples 5,5,5,5 -> out_max=5, out_idx=0, out_all_eq=1. Samples 0,0,0,0 -> out_max=0, out_idx=0, out_all_eq=1.
3. Samples 0,1,2,15 -> out_max=15, out_idx=3. Then samples 15,0,0,0 -> out_max=15, out_idx=0.
4. Backpressure:
   - Window 1,2,3,4 completes while out_ready=0, then 8,7,6 are accepted.
   - With the 4th sample 5 presented: in_ready=0; result 4/idx 3 held stable for 5 cycles.
   - Raise out_ready: result 4 consumed, 5 accepted on that edge, next result out_max=8, out_idx=0.
5. Simultaneous: out_ready=1 on the same edge as the final sample of the next window -> out_valid stays 1 and the new result replaces the old one. Each result is observed exactly once.
6. Samples 7,9, then rst_n pulsed low asynchronously mid-cycle -> all outputs 0 immediately. Samples 1,2,3,4 afterwards -> out_max=4, out_idx=3.
